transmit: RTL and testbench



---
 rtl/serial_pkg.sv | 18 +
 rtl/transmit_if.sv | 12 +
 rtl/transmit_tx_hold_buf.sv | 30 +++
 rtl/transmit.sv | 89 ++++++++
 tb/tb_transmit.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/serial_pkg.sv
// Shared serial-link constants and types, used by both the transmitter and the paired receiver.
package serial_pkg;

  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned FRAME_BITS = 9;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned FCNT_W     = 16;

  localparam logic TERM_BIT = 1'b0;

  typedef logic [DATA_BITS-1:0] data_t;

  localparam data_t IDLE_WORD_DEFAULT = 8'h00;

  // bit_cnt value that carries the terminator; leaving it marks the frame boundary
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

endpackage

// File: rtl/transmit_if.sv
// Valid/ready word handshake between a byte source and the serial transmitter.
interface transmit_if;
  import serial_pkg::*;

  data_t word;
  logic  word_valid;
  logic  word_ready;

  modport master (output word, output word_valid, input word_ready);
  modport slave  (input word, input word_valid, output word_ready);

endinterface

// File: rtl/transmit_tx_hold_buf.sv
// One-entry holding buffer: accepts a word when empty, releases it on pop.
module tx_hold_buf
  import serial_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  data_t push_data,
  input  logic  push_valid,
  output logic  ready,
  output logic  full_c,
  output data_t data,
  input  logic  pop
);

  // Push and pop never coincide: pop only happens while full, push only while empty
  always_ff @(posedge clk) begin
    if (rst) begin
      ready <= 1'b1;
      data  <= '0;
    end else if (push_valid && ready) begin
      ready <= 1'b0;
      data  <= push_data;
    end else if (pop) begin
      ready <= 1'b1;
    end
  end

  assign full_c = ~ready;

endmodule

// File: rtl/transmit.sv
// Continuous 9-bit serial frame transmitter (8 data bits MSB first + 0 terminator).
// Optional TRANSMIT_FRAME_CNT_EN adds a 16-bit count of completed user frames.
module transmit
  import serial_pkg::*;
#(
  parameter data_t IDLE_WORD = IDLE_WORD_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  transmit_if.slave       bus,
  output logic            txd,
  output logic            sent
`ifdef TRANSMIT_FRAME_CNT_EN
  ,
  output logic [FCNT_W-1:0] frame_count
`endif
);

  logic [CNT_W-1:0] bit_cnt, bit_cnt_n;
  data_t            shift_reg, shift_n;
  logic             user_q, user_n;
  logic             sent_n, txd_n;
  logic             pop_c;
  logic             buf_ready, buf_full_c;
  data_t            buf_data;

  tx_hold_buf u_hold_buf (
    .clk        (clk),
    .rst        (rst),
    .push_data  (bus.word),
    .push_valid (bus.word_valid),
    .ready      (buf_ready),
    .full_c     (buf_full_c),
    .data       (buf_data),
    .pop        (pop_c)
  );

  assign bus.word_ready = buf_ready;

  // Next frame position; reload from buffer or IDLE_WORD at the boundary
  always_comb begin
    bit_cnt_n = bit_cnt + CNT_W'(1);
    shift_n   = {shift_reg[DATA_BITS-2:0], 1'b0};
    user_n    = user_q;
    sent_n    = 1'b0;
    pop_c     = 1'b0;
    if (bit_cnt == LAST_BIT) begin
      bit_cnt_n = '0;
      sent_n    = user_q;
      if (buf_full_c) begin
        shift_n = buf_data;
        user_n  = 1'b1;
        pop_c   = 1'b1;
      end else begin
        shift_n = IDLE_WORD;
        user_n  = 1'b0;
      end
    end
    txd_n = (bit_cnt_n == LAST_BIT) ? TERM_BIT : shift_n[DATA_BITS-1];
  end

  // txd is registered from the next-state decode so it has no input-to-output path
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt   <= '0;
      shift_reg <= IDLE_WORD;
      user_q    <= 1'b0;
      sent      <= 1'b0;
      txd       <= IDLE_WORD[DATA_BITS-1];
    end else begin
      bit_cnt   <= bit_cnt_n;
      shift_reg <= shift_n;
      user_q    <= user_n;
      sent      <= sent_n;
      txd       <= txd_n;
    end
  end

`ifdef TRANSMIT_FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_count <= '0;
    end else if (sent_n) begin
      frame_count <= frame_count + FCNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_transmit.sv
// Directed self-checking bench for the serial transmitter; every cycle's txd/sent is compared
// against a hand-listed expected frame sequence.
module tb_transmit;
  import serial_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic txd, sent;
`ifdef TRANSMIT_FRAME_CNT_EN
  logic [15:0] frame_count;
`endif

  always #5 clk = ~clk;

  transmit_if bus ();

  transmit dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .txd         (txd),
    .sent        (sent)
`ifdef TRANSMIT_FRAME_CNT_EN
    ,
    .frame_count (frame_count)
`endif
  );

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          exp_fc = 0;
  logic [7:0]  exp_byte [8];
  bit          exp_user [8];
  logic [7:0]  q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic drive();
    bus.word_valid = (q.size() > 0);
    bus.word       = (q.size() > 0) ? q[0] : 8'h00;
  endtask

  task automatic set_frames(input logic [7:0] b0, b1, b2, b3, b4, b5, input logic [5:0] um);
    exp_byte[0] = b0; exp_byte[1] = b1; exp_byte[2] = b2;
    exp_byte[3] = b3; exp_byte[4] = b4; exp_byte[5] = b5;
    exp_byte[6] = 8'h00; exp_byte[7] = 8'h00;
    for (int i = 0; i < 8; i++) exp_user[i] = (i < 6) ? um[i] : 1'b0;
  endtask

  task automatic check_cycle();
    int         f;
    int         pos;
    logic [7:0] b;
    logic       e_txd;
    logic       e_sent;
    f      = cyc / 9;
    pos    = cyc % 9;
    b      = exp_byte[f];
    e_txd  = (pos == 8) ? 1'b0 : b[7-pos];
    e_sent = (pos == 0) && (f > 0) && exp_user[f-1];
    chk("txd", 32'(txd), 32'(e_txd));
    chk("sent", 32'(sent), 32'(e_sent));
`ifdef TRANSMIT_FRAME_CNT_EN
    if (e_sent) exp_fc++;
    chk("frame_count", 32'(frame_count), 32'(exp_fc));
`endif
  endtask

  task automatic tick();
    logic acc;
    acc = bus.word_valid && bus.word_ready;
    @(posedge clk);
    #1;
    cyc++;
    if (acc) void'(q.pop_front());
    drive();
    check_cycle();
  endtask

  task automatic do_reset();
    q.delete();
    drive();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    cyc    = 0;
    exp_fc = 0;
    check_cycle();
    chk("ready_after_rst", 32'(bus.word_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    q.delete();
    drive();

    // Idle line: fill frames of 0x00 only
    set_frames(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 6'b000000);
    do_reset();
    repeat (27) begin
      tick();
      chk("idle_ready", 32'(bus.word_ready), 32'd1);
    end

    // Single word offered at cycle 2, sent in frame 1
    set_frames(8'h00, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 6'b000010);
    do_reset();
    repeat (2) tick();
    q.push_back(8'hA5);
    drive();
    chk("a5_ready_before", 32'(bus.word_ready), 32'd1);
    tick();
    chk("a5_ready_held", 32'(bus.word_ready), 32'd0);
    repeat (5) tick();
    chk("a5_ready_c8", 32'(bus.word_ready), 32'd0);
    tick();
    chk("a5_ready_c9", 32'(bus.word_ready), 32'd1);
    repeat (11) tick();

    // Back-to-back words, one frame per 9 cycles
    set_frames(8'h00, 8'h3C, 8'hFF, 8'h01, 8'h00, 8'h00, 6'b001110);
    do_reset();
    q.push_back(8'h3C);
    q.push_back(8'hFF);
    q.push_back(8'h01);
    drive();
    repeat (44) tick();
    chk("b2b_drained", 32'(q.size()), 32'd0);

    // Word offered on the boundary edge waits a whole fill frame
    set_frames(8'h00, 8'h00, 8'h5A, 8'h00, 8'h00, 8'h00, 6'b000100);
    do_reset();
    repeat (8) tick();
    q.push_back(8'h5A);
    drive();
    chk("bnd_ready_c8", 32'(bus.word_ready), 32'd1);
    tick();
    chk("bnd_ready_c9", 32'(bus.word_ready), 32'd0);
    repeat (20) tick();

    // Reset at bit 4 of a user frame with a second word buffered
    set_frames(8'h00, 8'h81, 8'h7E, 8'h00, 8'h00, 8'h00, 6'b000110);
    do_reset();
    q.push_back(8'h81);
    q.push_back(8'h7E);
    drive();
    repeat (13) tick();
    chk("rst_buf_full", 32'(bus.word_ready), 32'd0);
    set_frames(8'h00, 8'hC3, 8'h00, 8'h00, 8'h00, 8'h00, 6'b000010);
    do_reset();
    q.push_back(8'hC3);
    drive();
    repeat (27) tick();
`ifdef TRANSMIT_FRAME_CNT_EN
    chk("frame_count_final", 32'(frame_count), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
